// File: rtl/spi_sample_target.sv
// spi_sample_target: SPI mode-0 target used as an on-chip codec stand-in.
// Each FRAME_BITS-bit frame shifts one queued sample out on miso. In the
// same frame it captures the initiator's mosi word and presents it with a
// one-cycle rx_valid strobe. sclk/cs/mosi are oversampled in the wb_clk_i
// domain, so f(wb_clk_i) must be at least 8 x f(sclk).
//
// Optional feature: define SPI_SAMPLE_TARGET_LOOPBACK_EN to add loopback_en.
// While loopback_en=1, every received word is pushed back into the TX FIFO,
// and external pushes are blocked.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   sclk, cs, mosi          SPI pins from the initiator (asynchronous)
//   miso, miso_oe           SPI data out and its pad output-enable
//   tx_data/valid/ready     sample push interface into the TX FIFO
//   rx_data, rx_valid       last complete mosi word and its update strobe
//   underrun, frame_err     sticky status flags, cleared by status_clr
//   loopback_en             (optional) route received words back to TX
module spi_sample_target #(
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned TX_DEPTH    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  underrun,
  output logic                  frame_err,
`ifdef SPI_SAMPLE_TARGET_LOOPBACK_EN
  input  logic                  loopback_en,
`endif
  input  logic                  status_clr
);

  localparam int unsigned PTR_W = $clog2(TX_DEPTH);
  localparam int unsigned CNT_W = $clog2(TX_DEPTH + 1);
  localparam int unsigned BIT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Pin synchronizers plus one extra flop per edge-detected pin.
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic                   r_cs_prev;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  logic w_sclk_s;
  logic w_cs_s;
  logic w_mosi_s;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_rise;
  logic w_cs_fall;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise =  w_sclk_s & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk_s &  r_sclk_prev;
  assign w_cs_rise   =  w_cs_s   & ~r_cs_prev;
  assign w_cs_fall   = ~w_cs_s   &  r_cs_prev;

  logic w_lb_en;
`ifdef SPI_SAMPLE_TARGET_LOOPBACK_EN
  assign w_lb_en = loopback_en;
`else
  assign w_lb_en = 1'b0;
`endif

  state_t                r_state;
  state_t                w_state_nxt;
  logic [FRAME_BITS-1:0] r_tx_shift;
  logic [FRAME_BITS-1:0] r_rx_shift;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic                  w_load;
  logic                  w_abort;
  logic                  w_complete;

  // Frame sequencing; datapath updates are derived from the strobes below.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_abort     = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_load = 1'b1;
        if (w_cs_rise) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_cs_rise) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_sclk_rise && (r_bit_cnt == BIT_W'(FRAME_BITS - 1))) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (w_cs_rise) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // TX FIFO: circular buffer; pointers wrap naturally (depth is a power of two).
  logic [FRAME_BITS-1:0] r_mem [TX_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_count_nxt;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic [FRAME_BITS-1:0] w_push_data;

  logic [FRAME_BITS-1:0] w_tx_shift_nxt;
  logic [FRAME_BITS-1:0] w_rx_shift_nxt;
  logic [BIT_W-1:0]      w_bit_cnt_nxt;

  assign w_full  = (r_count == CNT_W'(TX_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = w_load & ~w_empty;
  // A simultaneous pop frees an entry, so a push is honoured even when full.
  assign w_push  = w_lb_en ? (w_complete & (~w_full | w_pop))
                           : (tx_valid   & (~w_full | w_pop));
  assign w_push_data = w_lb_en ? w_rx_shift_nxt : tx_data;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Shift registers: capture on sclk rise, advance miso on sclk fall.
  always_comb begin
    w_tx_shift_nxt = r_tx_shift;
    w_rx_shift_nxt = r_rx_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    if (w_load) begin
      w_tx_shift_nxt = w_pop ? r_mem[r_rd_ptr] : '0;
      w_rx_shift_nxt = '0;
      w_bit_cnt_nxt  = '0;
    end else if (r_state == ST_SHIFT) begin
      if (w_sclk_rise) begin
        w_rx_shift_nxt = {r_rx_shift[FRAME_BITS-2:0], w_mosi_s};
        w_bit_cnt_nxt  = r_bit_cnt + BIT_W'(1);
      end
      if (w_sclk_fall) begin
        w_tx_shift_nxt = {r_tx_shift[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  logic                  r_miso;
  logic                  r_miso_oe;
  logic                  r_tx_ready;
  logic [FRAME_BITS-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_underrun;
  logic                  r_frame_err;

  // State, datapath and registered outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_bit_cnt   <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_tx_ready  <= 1'b1;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_count    <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      // miso follows the next shift value so the MSB appears right after LOAD.
      r_miso     <= (w_state_nxt == ST_SHIFT) ? w_tx_shift_nxt[FRAME_BITS-1] : 1'b0;
      r_miso_oe  <= (w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_DONE);
      r_tx_ready <= ~w_lb_en & (w_count_nxt != CNT_W'(TX_DEPTH));
      r_rx_valid <= w_complete;
      if (w_complete) r_rx_data <= w_rx_shift_nxt;
      // Sticky flags: a set event wins over a same-cycle clear.
      r_underrun  <= (w_load & w_empty) | (r_underrun  & ~status_clr);
      r_frame_err <= w_abort            | (r_frame_err & ~status_clr);
    end
  end

  // FIFO storage needs no reset; the pointers and count define its contents.
  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  assign miso      = r_miso;
  assign miso_oe   = r_miso_oe;
  assign tx_ready  = r_tx_ready;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign underrun  = r_underrun;
  assign frame_err = r_frame_err;

endmodule

// File: doc/spi_sample_target.md
Name: spi_sample_target

Overview:
- SPI target (responder) for the pedal's SPI audio link. It is the other end of the SPI initiator that drives sclk/mosi/cs and samples miso.
- Each 16-bit frame does two things at once:
  - shifts one queued 16-bit sample out on miso (the "ADC" word the initiator reads);
  - captures the initiator's 16-bit mosi word (the "DAC" word) and presents it as a one-cycle rx strobe.
- Used as an on-chip loopback/codec stand-in. SPI pins are oversampled in the wb_clk_i domain.

Parameters:
- FRAME_BITS, 16, bits per SPI frame, MSB first.
- TX_DEPTH, 4, TX FIFO entries, power of two, >= 2.
- SYNC_STAGES, 2, synchronizer flops on sclk, cs, mosi; >= 2.

Ports:
- wb_clk_i  input  1  system clock; all logic is in this domain.
- wb_rst_i  input  1  reset, synchronous, active-high.
- sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0). Requirement: f(wb_clk_i) >= 8 x f(sclk).
- cs  input  1  chip select, active-low.
- mosi  input  1  serial data from the initiator.
- miso  output  1  serial data to the initiator.
- miso_oe  output  1  1 while a frame is selected (cs synced low). The pad drives miso only when this is 1.
- tx_data  input  FRAME_BITS  sample to queue.
- tx_valid  input  1  push request.
- tx_ready  output  1  FIFO not full. A push occurs when tx_valid and tx_ready are both 1 on a clock edge.
- rx_data  output  FRAME_BITS  last complete mosi word.
- rx_valid  output  1  one-cycle strobe when rx_data updates.
- underrun  output  1  sticky: a frame started with the TX FIFO empty.
- frame_err  output  1  sticky: cs rose before FRAME_BITS sclk rising edges.
- status_clr  input  1  one-cycle pulse; clears underrun and frame_err.

Behaviour:
- Reset values:
  - miso=0, miso_oe=0, rx_data=0, rx_valid=0, underrun=0, frame_err=0, tx_ready=1.
  - FIFO empty, state IDLE.
  - Synchronizers reset to cs=1, sclk=0, mosi=0.
- Edge detection: on synchronized pins, from the current and previous samples. An effect lands SYNC_STAGES+1 wb_clk_i cycles after the pin edge.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE:
    - On a cs falling edge, go to LOAD.
    - sclk edges are ignored while cs is high.
  - LOAD (1 cycle):
    - If the FIFO is non-empty, pop the head into tx_shift.
    - If the FIFO is empty, load 0 and set underrun.
    - Clear bit_cnt and rx_shift; set miso_oe=1; go to SHIFT.
    - miso = tx_shift MSB from the next cycle onward.
  - SHIFT:
    - sclk rising edge: rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_sync}; bit_cnt++.
    - sclk falling edge: tx_shift shifts left, filling with 0.
    - When bit_cnt reaches FRAME_BITS, go to DONE.
    - cs rising edge with bit_cnt < FRAME_BITS: set frame_err, no rx_valid, go to IDLE, miso_oe=0.
  - DONE:
    - rx_data <= rx_shift and rx_valid=1 for exactly one cycle.
    - Then wait for cs rising edge and go to IDLE.
    - Extra sclk edges in DONE are ignored; miso=0.
- miso_oe goes to 0 on the cycle the cs rising edge is detected.
- TX FIFO:
  - Circular buffer with wrap-around pointers plus a count.
  - tx_ready = (count != TX_DEPTH).
  - A push and a pop in the same cycle are both honoured and count is unchanged. When full, this still accepts the push because the pop frees an entry.
  - A push while full is dropped (tx_ready=0); no flag is raised.
- status_clr:
  - Clears the sticky flags.
  - If a set event occurs in the same cycle, set wins.
- A cs falling edge in any state other than IDLE (a glitch) is ignored.
- Reset mid-frame:
  - Return to IDLE, flush the FIFO, miso_oe=0.
  - The initiator sees miso=0 for the rest of the frame.

Optional Feature:
- Macro: SPI_SAMPLE_TARGET_LOOPBACK_EN.
- Defined:
  - Adds input port loopback_en (1 bit).
  - While loopback_en=1, each DONE word is pushed into the TX FIFO in the same cycle as rx_valid, and is dropped if the FIFO is full.
  - tx_ready is forced to 0, so external pushes are blocked.
  - The initiator reads back its own word one frame later.
- Undefined: no port and no loopback logic; behaviour is exactly as above.

Test Plan:
- Push 0xA5C3; initiator runs one 16-bit frame with mosi=0x1234 -> miso bits read 0xA5C3 MSB first; one rx_valid pulse with rx_data=0x1234; underrun=0; frame_err=0.
- Frame with FIFO empty, mosi=0xFFFF -> miso reads 0x0000; underrun=1 and stays 1 until status_clr; rx_data=0xFFFF.
- cs raised after 9 sclk rising edges -> frame_err=1; no rx_valid; rx_data keeps its previous value; next full frame (mosi=0x0F0F) completes normally with rx_data=0x0F0F.
- FIFO fill and wrap:
  - Push 0x0001..0x0004 -> tx_ready=0; a push of 0x0005 is dropped.
  - Six frames -> miso 0x0001, 0x0002, 0x0003, 0x0004, then 0x0000 twice with underrun=1.
  - Pushing during frame 1's LOAD with the FIFO full is accepted.
- wb_rst_i asserted mid-frame after 5 bits -> miso_oe=0, FIFO empty, all flags 0; no rx_valid for that frame.
- With SPI_SAMPLE_TARGET_LOOPBACK_EN and loopback_en=1: frame 1 mosi=0xBEEF -> frame 2 miso reads 0xBEEF; tx_ready=0 throughout.
